// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_pkg
// Brief    : Control-word types, encodings and decode helpers for ctrl_pipe.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pipe_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [1:0] {
        fwd_regfile = 2'd0,
        fwd_ex_mem  = 2'd1,
        fwd_mem_wb  = 2'd2
    } fwd_sel_t;

    typedef enum logic [2:0] {
        md_mul  = 3'd0, md_mulh = 3'd1, md_mulhsu = 3'd2, md_mulhu = 3'd3,
        md_div  = 3'd4, md_divu = 3'd5, md_rem    = 3'd6, md_remu  = 3'd7
    } md_op_t;

    typedef enum logic [3:0] {
        alu_add = 4'd0, alu_sll = 4'd1, alu_slt = 4'd2, alu_sltu = 4'd3,
        alu_xor = 4'd4, alu_srl = 4'd5, alu_or  = 4'd6, alu_and  = 4'd7,
        alu_sub = 4'd8, alu_sra = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        pc_plus4    = 2'd0,
        pc_alu      = 2'd1,
        pc_alu_mod2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic [2:0] {
        rf_alu = 3'd0, rf_cmp = 3'd1, rf_uimm = 3'd2,
        rf_load = 3'd3, rf_pc4 = 3'd4, rf_md = 3'd5
    } rfmux_sel_t;

    typedef struct packed {
        alu_op_t    aluop;
        logic       alumux1_pc;
        logic       alumux2_imm;
        logic [2:0] cmpop;
        logic       is_branch;
        pcmux_sel_t pcmux;
        logic       is_load;
        logic       is_md;
        md_op_t     md_op;
        logic       dmem_read;
        logic       dmem_write;
        logic [2:0] mem_funct3;
        logic       load_regfile;
        rfmux_sel_t rfmux;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrlex_reg_t;

    typedef struct packed {
        logic       dmem_read;
        logic       dmem_write;
        logic [2:0] mem_funct3;
        logic       is_load;
        logic       load_regfile;
        rfmux_sel_t rfmux;
        logic [4:0] rd;
    } ctrlmem_reg_t;

    typedef struct packed {
        logic       load_regfile;
        rfmux_sel_t rfmux;
        logic [4:0] rd;
    } ctrlwb_reg_t;

    // All-zero encodings are the bubble: no writes, pc_plus4, alu_add.
    localparam ctrlex_reg_t  c_ctrlex_default  = ctrlex_reg_t'('0);
    localparam ctrlmem_reg_t c_ctrlmem_default = ctrlmem_reg_t'('0);
    localparam ctrlwb_reg_t  c_ctrlwb_default  = ctrlwb_reg_t'('0);

    function automatic ctrlex_reg_t decode(
        input  logic [6:0] op,
        input  logic [2:0] f3,
        input  logic [6:0] f7,
        input  logic [4:0] rd,
        input  logic [4:0] rs1,
        input  logic [4:0] rs2,
        input  logic       m_en,
        output logic       illegal
    );
        ctrlex_reg_t c;
        logic        use1;
        logic        use2;
        c       = c_ctrlex_default;
        illegal = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        case (op)
            op_lui: begin
                c.load_regfile = 1'b1;
                c.rfmux        = rf_uimm;
            end
            op_auipc: begin
                c.alumux1_pc   = 1'b1;
                c.alumux2_imm  = 1'b1;
                c.load_regfile = 1'b1;
            end
            op_jal: begin
                c.alumux1_pc   = 1'b1;
                c.alumux2_imm  = 1'b1;
                c.pcmux        = pc_alu;
                c.load_regfile = 1'b1;
                c.rfmux        = rf_pc4;
            end
            op_jalr: begin
                use1           = 1'b1;
                c.alumux2_imm  = 1'b1;
                c.pcmux        = pc_alu_mod2;
                c.load_regfile = 1'b1;
                c.rfmux        = rf_pc4;
                illegal        = (f3 != 3'b000);
            end
            op_br: begin
                use1          = 1'b1;
                use2          = 1'b1;
                c.alumux1_pc  = 1'b1;
                c.alumux2_imm = 1'b1;
                c.is_branch   = 1'b1;
                c.cmpop       = f3;
                illegal       = (f3[2:1] == 2'b01);
            end
            op_load: begin
                use1           = 1'b1;
                c.alumux2_imm  = 1'b1;
                c.dmem_read    = 1'b1;
                c.is_load      = 1'b1;
                c.mem_funct3   = f3;
                c.load_regfile = 1'b1;
                c.rfmux        = rf_load;
                illegal        = (f3[1:0] == 2'b11) || (f3[2] && f3[1]);
            end
            op_store: begin
                use1          = 1'b1;
                use2          = 1'b1;
                c.alumux2_imm = 1'b1;
                c.dmem_write  = 1'b1;
                c.mem_funct3  = f3;
                illegal       = f3[2] || (f3[1:0] == 2'b11);
            end
            op_imm: begin
                use1           = 1'b1;
                c.alumux2_imm  = 1'b1;
                c.load_regfile = 1'b1;
                c.aluop        = alu_op_t'({(f3 == 3'b101) && f7[5], f3});
                illegal        = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                                 ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            op_reg: begin
                use1 = 1'b1;
                use2 = 1'b1;
                if (f7 == 7'h01) begin
                    c.is_md        = 1'b1;
                    c.md_op        = md_op_t'(f3);
                    c.load_regfile = 1'b1;
                    c.rfmux        = rf_md;
                    illegal        = !m_en;
                end else begin
                    c.load_regfile = 1'b1;
                    c.aluop        = alu_op_t'({f7[5], f3});
                    illegal        = !((f7 == 7'h00) ||
                                       ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
                end
            end
            default: illegal = 1'b1;
        endcase
        // slt/sltu produce their result through the comparator (blt/bltu)
        if ((op == op_imm || (op == op_reg && !c.is_md)) && (f3[2:1] == 2'b01)) begin
            c.rfmux = rf_cmp;
            c.cmpop = {1'b1, f3[0], 1'b0};
        end
        c.rd  = c.load_regfile ? rd : 5'd0;
        c.rs1 = use1 ? rs1 : 5'd0;
        c.rs2 = use2 ? rs2 : 5'd0;
        if (illegal) begin
            c = c_ctrlex_default;
        end
        return c;
    endfunction

    function automatic ctrlmem_reg_t ex_to_mem(input ctrlex_reg_t e);
        ctrlmem_reg_t m;
        m.dmem_read    = e.dmem_read;
        m.dmem_write   = e.dmem_write;
        m.mem_funct3   = e.mem_funct3;
        m.is_load      = e.is_load;
        m.load_regfile = e.load_regfile;
        m.rfmux        = e.rfmux;
        m.rd           = e.rd;
        return m;
    endfunction

    function automatic ctrlwb_reg_t mem_to_wb(input ctrlmem_reg_t m);
        ctrlwb_reg_t w;
        w.load_regfile = m.load_regfile;
        w.rfmux        = m.rfmux;
        w.rd           = m.rd;
        return w;
    endfunction

    function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        return (rd != 5'd0) && ((rs1 == rd) || (rs2 == rd));
    endfunction

    function automatic fwd_sel_t fwd_pick(
        input logic [4:0]   rs,
        input logic         mem_v,
        input ctrlmem_reg_t m,
        input logic         wb_v,
        input ctrlwb_reg_t  w
    );
        if ((rs != 5'd0) && mem_v && m.load_regfile && !m.is_load && (m.rd == rs)) begin
            return fwd_ex_mem;
        end
        if ((rs != 5'd0) && wb_v && w.load_regfile && (w.rd == rs)) begin
            return fwd_mem_wb;
        end
        return fwd_regfile;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_md_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_md_seq
// Brief    : Multi-cycle MUL/DIV occupancy counter and start pulse.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe_md_seq #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_is_div,
    input  logic i_freeze,
    output logic o_start,
    output logic o_busy
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CW-1:0] c_mul_init = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] c_div_init = CW'(DIV_LATENCY - 1);

    logic [CW-1:0] r_cnt;
    logic          r_start;

    // Counter is loaded on the same edge the op enters EX, so the op's first
    // EX cycle already shows busy; it leaves EX when the count reaches zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= i_load;
            if (i_load) begin
                r_cnt <= i_is_div ? c_div_init : c_mul_init;
            end else if (!i_freeze && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_start = r_start;
    assign o_busy  = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Brief    : RV32I 5-stage pipeline control: decode, ID/EX-EX/MEM-MEM/WB
//            control registers, hazard stalls, flush, forwarding, M-ext timing.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int M_EXT       = 1,
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 33,
    parameter int FWD_EN      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [4:0]   rd_in,
    input  logic [4:0]   rs1_in,
    input  logic [4:0]   rs2_in,
    input  logic         mem_stall,
    input  logic         ex_flush,
    output ctrlex_reg_t  ctrlex,
    output ctrlmem_reg_t ctrlmem,
    output ctrlwb_reg_t  ctrlwb,
    output logic         ex_valid,
    output logic         mem_valid,
    output logic         wb_valid,
    output logic         stall_id,
    output fwd_sel_t     fwd_a_sel,
    output fwd_sel_t     fwd_b_sel,
    output logic         md_start,
    output logic         md_busy,
    output logic         illegal
);

    ctrlex_reg_t  r_ex;
    ctrlmem_reg_t r_mem;
    ctrlwb_reg_t  r_wb;
    logic         r_ex_valid;
    logic         r_mem_valid;
    logic         r_wb_valid;

    ctrlex_reg_t  w_dec;
    logic         w_dec_illegal;
    logic         w_id_ok;
    logic         w_hit_ex;
    logic         w_hit_mem;
    logic         w_hit_wb;
    logic         w_hazard;
    logic         w_md_busy;
    logic         w_md_load;

    always_comb begin
        w_dec_illegal = 1'b0;
        w_dec = decode(opcode, funct3, funct7, rd_in, rs1_in, rs2_in,
                       (M_EXT != 0), w_dec_illegal);
    end

    assign illegal = id_valid & w_dec_illegal;
    assign w_id_ok = id_valid & ~w_dec_illegal;

    // Unused source fields are zeroed by decode, so src_hit only sees real reads.
    assign w_hit_ex  = r_ex_valid  & r_ex.load_regfile  & src_hit(r_ex.rd,  w_dec.rs1, w_dec.rs2);
    assign w_hit_mem = r_mem_valid & r_mem.load_regfile & src_hit(r_mem.rd, w_dec.rs1, w_dec.rs2);
    assign w_hit_wb  = r_wb_valid  & r_wb.load_regfile  & src_hit(r_wb.rd,  w_dec.rs1, w_dec.rs2);

    assign w_hazard = w_id_ok & ((FWD_EN != 0) ? (w_hit_ex & r_ex.is_load)
                                               : (w_hit_ex | w_hit_mem | w_hit_wb));

    assign stall_id  = mem_stall | w_md_busy | (~ex_flush & w_hazard);
    assign w_md_load = ~mem_stall & ~w_md_busy & ~ex_flush & ~w_hazard & w_id_ok & w_dec.is_md;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex        <= c_ctrlex_default;
            r_mem       <= c_ctrlmem_default;
            r_wb        <= c_ctrlwb_default;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else if (!mem_stall) begin
            if (w_md_busy) begin
                r_mem       <= c_ctrlmem_default;
                r_mem_valid <= 1'b0;
            end else begin
                r_mem       <= ex_to_mem(r_ex);
                r_mem_valid <= r_ex_valid;
                if (ex_flush || w_hazard || !w_id_ok) begin
                    r_ex       <= c_ctrlex_default;
                    r_ex_valid <= 1'b0;
                end else begin
                    r_ex       <= w_dec;
                    r_ex_valid <= 1'b1;
                end
            end
            r_wb       <= mem_to_wb(r_mem);
            r_wb_valid <= r_mem_valid;
        end
    end

    ctrl_pipe_md_seq #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_LATENCY (DIV_LATENCY)
    ) u_md_seq (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_md_load),
        .i_is_div (funct3[2]),
        .i_freeze (mem_stall),
        .o_start  (md_start),
        .o_busy   (w_md_busy)
    );

    assign md_busy   = w_md_busy;
    assign fwd_a_sel = (FWD_EN != 0) ? fwd_pick(r_ex.rs1, r_mem_valid, r_mem, r_wb_valid, r_wb)
                                     : fwd_regfile;
    assign fwd_b_sel = (FWD_EN != 0) ? fwd_pick(r_ex.rs2, r_mem_valid, r_mem, r_wb_valid, r_wb)
                                     : fwd_regfile;

    assign ctrlex    = r_ex;
    assign ctrlmem   = r_mem;
    assign ctrlwb    = r_wb;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Parametrised next-generation control unit for the RV32I 5-stage pipeline. Decodes ID-stage fields into EX/MEM/WB control words and carries them through registered ID/EX, EX/MEM and MEM/WB stages, each with a valid bit. Adds load-use hazard stalls, branch flush, forwarding-select generation and optional multi-cycle M-extension sequencing. Sits between the ID-stage instruction register and the datapath muxes.

Parameters:
M_EXT, 1, enables decode of op_reg with funct7=7'b0000001 (MUL/DIV); 0 = such encodings decode as bubbles
MUL_LATENCY, 3, EX-stage cycles for MUL* (>=1)
DIV_LATENCY, 33, EX-stage cycles for DIV*/REM* (>=1)
FWD_EN, 1, 0 forces fwd_a_sel/fwd_b_sel to regfile and makes every RAW against EX/MEM/WB a stall

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a valid instruction
opcode  in  7  rv32i_opcode of ID instruction
funct3  in  3  ID funct3
funct7  in  7  ID funct7
rd_in, rs1_in, rs2_in  in  5 each  ID register indices
mem_stall  in  1  dmem not ready; freezes whole pipeline
ex_flush  in  1  EX resolved taken branch/jump; kill ID/IF
ctrlex  out  ctrlex_reg_t  ID/EX control word
ctrlmem  out  ctrlmem_reg_t  EX/MEM control word
ctrlwb  out  ctrlwb_reg_t  MEM/WB control word
ex_valid, mem_valid, wb_valid  out  1 each  stage valid bits
stall_id  out  1  hold PC and IF/ID this cycle
fwd_a_sel, fwd_b_sel  out  fwd_sel_t (2)  EX operand source: regfile / ex_mem / mem_wb
md_start  out  1  one-cycle pulse starting multiplier/divider
md_busy  out  1  M op occupying EX
illegal  out  1  ID opcode/funct not decodable (combinational)

Behaviour:
- Reset (rst=0, async): all valids 0, control words to default (load_regfile=0, dmem_read/write=0, pcmux=pc_plus4, is_branch=0, is_md=0), md counter 0, md_start/md_busy/stall_id 0, fwd selects regfile.
- Decode: RV32I encoding of the existing control word unchanged; adds is_load, md_op, is_md; invalid ID or illegal → bubble (valid 0, all write/enables 0).
- Priority per cycle: mem_stall > md_busy > ex_flush > load-use > normal advance.
- mem_stall=1: no stage register changes; md counter holds; stall_id=1. Datapath keeps ex_flush asserted while frozen; flush acts on first unfrozen cycle.
- md_busy=1: ID/EX holds, EX/MEM gets bubble, MEM/WB advances; stall_id=1.
- ex_flush=1 (not frozen): ID/EX loads bubble, ID instruction discarded, stall_id=0; EX instruction advances normally.
- Load-use: ex_valid & ctrlex.is_load & rd!=0 & rd matches a source used by ID opcode → stall_id=1, ID/EX gets bubble, 1 cycle. FWD_EN=0: any match in EX, MEM or WB stalls.
- Forwarding (combinational, EX stage): rs!=0 matching EX/MEM rd with load_regfile & mem_valid & !is_load → ex_mem; else matching MEM/WB writer → mem_wb; else regfile. EX/MEM wins ties.
- MD sequencer: on cycle a valid is_md word enters ID/EX, next cycle md_start=1 and counter loads latency-1; md_busy = counter!=0; decrements each unfrozen cycle; latency 1 → no busy cycles. Flush never kills EX.
- Reset mid-MD: counter cleared, no md_start.

Decomposition:
- pipeline_pkg: fwd_sel_t {fwd_regfile=0, fwd_ex_mem=1, fwd_mem_wb=2}; md_op_t (8 ops = funct3); ctrlex_reg_t gains is_md, md_op, is_load; ctrl_default constants.
- Sub-module md_seq: counter, md_start, md_busy, parametrised by both latencies.

Test Plan:
- Reset low mid-stream → all valids 0, md_busy 0, fwd regfile within same cycle (async).
- lw x5,0(x1) then add x6,x5,x2 → stall_id=1 one cycle, bubble in EX, then fwd_a_sel=mem_wb for add.
- add x3,x1,x2; sub x4,x3,x3 → no stall, fwd_a_sel=fwd_b_sel=ex_mem; repeat with rd=x0 → regfile.
- mul x7,x1,x2 with MUL_LATENCY=3 → md_start pulse, md_busy 2 cycles, stall_id 2 cycles, EX/MEM 2 bubbles; M_EXT=0 → illegal=1, bubble.
- beq taken with ex_flush=1 coincident with load-use in ID → ID/EX bubble, stall_id=0.
- mem_stall=1 for 4 cycles with ex_flush held → all registers frozen; flush applied on release cycle.
